spi_request_arbiter: RTL and testbench
======================================

Name: spi_request_arbiter

Overview:
- Shares one SPI master (8-bit, SCLK = clk, LSB-first, 3 chip selects) between NUM_REQ on-chip requesters.
- Sequences each transfer:
  - arbitrates;
  - drives the master's start, slaveSelect and masterDataToSend;
  - times the fixed-length transfer;
  - captures masterDataReceived and returns it to the winner with a one-cycle ack.
- Sits between the microcontroller-side clients and the SPI master instance.

Parameters:
- NUM_REQ, 3: number of requesters (2..4).
- XFER_CYCLES, 10: clk cycles from m_start pulse to valid m_data_received (covers 8 bits plus master flag/CS release).
- GAP_CYCLES, 1: idle cycles after each ack before next arbitration (CS deassert time).

Ports:
- clk  input  1  system clock; same clock as the SPI master.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester request; held high until ack.
- req_sel  input  2*NUM_REQ  per-requester slave select; slice i = bits [2i+1:2i].
- req_data  input  8*NUM_REQ  per-requester byte to send; slice i = bits [8i+7:8i].
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_data  output  8  received byte; valid while any ack bit is high.
- err  output  1  pulses with ack when req_sel was 2'b11.
- busy  output  1  high in every state except IDLE.
- grant_id  output  2  index of current/last granted requester.
- m_start  output  1  start pulse to master.
- m_slave_select  output  2  to master slaveSelect.
- m_data_to_send  output  8  to master masterDataToSend.
- m_data_received  input  8  from master masterDataReceived.

Behaviour:
- All outputs registered.
- Reset asserted (reset=0) at any time, including mid-transfer:
  - state = IDLE; ack = 0, err = 0, busy = 0, m_start = 0;
  - m_slave_select = 2'b11, m_data_to_send = 0, rsp_data = 0, grant_id = 0;
  - rr pointer = NUM_REQ-1, so requester 0 wins first.
  - An in-flight transfer is abandoned silently; no ack is issued.
- States: IDLE, START, XFER, CAPTURE, GAP.
- IDLE:
  - If any req is high, select winner by round-robin, searching from pointer+1 modulo NUM_REQ.
  - Latch grant_id, m_slave_select = req_sel[winner] and m_data_to_send = req_data[winner]; set pointer = winner.
  - If req_sel[winner] == 2'b11: go to CAPTURE with err_pending set; no master access.
  - Otherwise go to START.
- START: m_start = 1 for exactly this cycle; go to XFER with cnt = 0.
- XFER:
  - m_start = 0; cnt increments each cycle.
  - When cnt == XFER_CYCLES-1: load rsp_data <= m_data_received and go to CAPTURE.
- CAPTURE:
  - ack[grant_id] = 1 for this one cycle; err = err_pending.
  - For an err transfer, rsp_data = 8'hFF.
  - Go to GAP, or to IDLE directly if GAP_CYCLES == 0.
- GAP:
  - Counts GAP_CYCLES cycles, then go to IDLE.
  - m_slave_select returns to 2'b11 on entry.
- m_slave_select and m_data_to_send are stable from START through CAPTURE.
- Latency: req sampled at IDLE edge k → ack high in the cycle following edge k+XFER_CYCLES+1.
  - Error path: ack high in the cycle after edge k.
- Handshake:
  - Requester holds req, req_sel and req_data stable until ack.
  - Requester drops req in the cycle after ack. A req still high when IDLE is re-entered is treated as a new request.
- req changes outside IDLE are ignored; no preemption.
- Simultaneous requests: exactly one winner per arbitration.
- Fairness: a continuously requesting set is served cyclically, e.g. 0,1,2,0,...

Optional Feature:
- SPI_ARB_FIXED_PRIO_EN defined:
  - fixed priority, lowest index wins;
  - pointer register removed.
- Not defined: round-robin as above.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE..GAP);
  - SPI_DATA_W = 8;
  - SEL_NONE = 2'b11;
  - ERR_BYTE = 8'hFF.
- One natural sub-module: rr_arbiter (req vector + pointer → one-hot grant and index; combinational).
  - Compiles to a priority encoder under SPI_ARB_FIXED_PRIO_EN.

Test Plan:
- Single request:
  - req0 = 1, req_sel0 = 2'b01, req_data0 = 8'hA5; master model returns 8'h3C.
  - Required: m_start pulses once, m_slave_select = 2'b01, m_data_to_send = 8'hA5.
  - Required: ack = 3'b001 exactly XFER_CYCLES+2 cycles after sampling, with rsp_data = 8'h3C.
- Round-robin, all three requesters held high with distinct data:
  - Required: grant order 0,1,2,0.
  - Required: each ack carries the matching rsp_data.
  - Under SPI_ARB_FIXED_PRIO_EN: order 0,0,0 while req0 is re-raised each time.
- Invalid select:
  - req1 with req_sel1 = 2'b11.
  - Required: no m_start; ack = 3'b010, err = 1, rsp_data = 8'hFF one cycle after sampling.
- Reset mid-transfer:
  - Assert reset at XFER cnt = 4.
  - Required: all outputs return to reset values immediately; no ack.
  - Required: after release, pending req0 is served normally.
- Requests during busy:
  - Raise req2 during XFER of req0.
  - Required: req2 is not granted until after GAP_CYCLES.
  - Required: m_slave_select = 2'b11 during GAP.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and constants for spi_request_arbiter (SPI_ARB_FIXED_PRIO_EN selects fixed-priority arbitration)
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic [SPI_DATA_W-1:0] ERR_BYTE = 8'hFF;
  typedef enum logic [2:0] {IDLE, START, XFER, CAPTURE, GAP} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot grant and index, round-robin after ptr or fixed priority under SPI_ARB_FIXED_PRIO_EN
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
`ifndef SPI_ARB_FIXED_PRIO_EN
  input  logic [1:0]   ptr,
`endif
  output logic [N-1:0] grant,
  output logic [1:0]   idx
);
`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [1:0] j;
  // scan from farthest to nearest after ptr so the nearest requester is written last and wins
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = 2'((int'(ptr) + k) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
`else
  // scan from highest to lowest index so the lowest requester is written last and wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[k]) begin
        grant = '0;
        grant[k] = 1'b1;
        idx = 2'(k);
      end
  end
`endif
endmodule

// File: rtl/spi_request_arbiter.sv
// spi_request_arbiter: shares one 8-bit SPI master among NUM_REQ requesters; SPI_ARB_FIXED_PRIO_EN selects fixed priority
module spi_request_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int XFER_CYCLES = 10,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [2*NUM_REQ-1:0]           req_sel,
  input  logic [SPI_DATA_W*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]             ack,
  output logic [SPI_DATA_W-1:0]          rsp_data,
  output logic                           err,
  output logic                           busy,
  output logic [1:0]                     grant_id,
  output logic                           m_start,
  output logic [1:0]                     m_slave_select,
  output logic [SPI_DATA_W-1:0]          m_data_to_send,
  input  logic [SPI_DATA_W-1:0]          m_data_received
);
  localparam int CW = 8;
  state_t st;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] win_oh, gnt_oh;
  logic [1:0] win, win_sel;
  logic [SPI_DATA_W-1:0] win_data;
  assign win_sel = req_sel[{win, 1'b0} +: 2];
  assign win_data = req_data[{win, 3'b000} +: SPI_DATA_W];
`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [1:0] ptr;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req), .ptr(ptr), .grant(win_oh), .idx(win));
  // rotate priority past the most recent winner; reset value makes requester 0 win first
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= 2'(NUM_REQ - 1);
    else if (st == IDLE && |req) ptr <= win;
`else
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req), .grant(win_oh), .idx(win));
`endif
  // transfer sequencer: arbitrate, pulse start, time the transfer, ack with captured byte, then hold CS off for the gap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      cnt <= '0;
      gnt_oh <= '0;
      ack <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      m_start <= 1'b0;
      m_slave_select <= SEL_NONE;
      m_data_to_send <= '0;
      rsp_data <= '0;
      grant_id <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      m_start <= 1'b0;
      case (st)
        IDLE: if (|req) begin
          grant_id <= win;
          gnt_oh <= win_oh;
          m_slave_select <= win_sel;
          m_data_to_send <= win_data;
          busy <= 1'b1;
          if (win_sel == SEL_NONE) begin
            st <= CAPTURE;
            ack <= win_oh;
            err <= 1'b1;
            rsp_data <= ERR_BYTE;
          end else begin
            st <= START;
            m_start <= 1'b1;
          end
        end
        START: begin
          st <= XFER;
          cnt <= '0;
        end
        XFER: if (cnt == CW'(XFER_CYCLES - 1)) begin
          st <= CAPTURE;
          rsp_data <= m_data_received;
          ack <= gnt_oh;
        end else cnt <= cnt + 1'b1;
        CAPTURE: begin
          m_slave_select <= SEL_NONE;
          cnt <= '0;
          st <= (GAP_CYCLES == 0) ? IDLE : GAP;
          busy <= (GAP_CYCLES != 0);
        end
        GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
          st <= IDLE;
          busy <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_request_arbiter.sv
// tb_spi_request_arbiter: randomized scoreboard bench with a transaction-level arbitration model and SPI slave model
module tb_spi_request_arbiter;
  localparam int N = 3, XF = 10, GP = 1;
  logic clk = 1'b0, reset = 1'b1;
  logic [N-1:0] req = '0, ack, drop = '0;
  logic [2*N-1:0] req_sel = '0;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] rsp_data, m_data_to_send, m_data_received = '0;
  logic err, busy, m_start;
  logic [1:0] grant_id, m_slave_select;
  typedef struct {
    int id;
    logic [1:0] sel;
    logic [7:0] data;
    logic [7:0] rsp;
    logic er;
  } item_t;
  item_t exp_q[$];
  int checks = 0, errors = 0, mptr = N - 1;

  spi_request_arbiter #(.NUM_REQ(N), .XFER_CYCLES(XF), .GAP_CYCLES(GP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_sel(req_sel), .req_data(req_data),
    .ack(ack), .rsp_data(rsp_data), .err(err), .busy(busy), .grant_id(grant_id),
    .m_start(m_start), .m_slave_select(m_slave_select), .m_data_to_send(m_data_to_send),
    .m_data_received(m_data_received)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] slave_resp(logic [7:0] d, logic [1:0] s);
    return d ^ 8'h98 ^ {6'b0, s};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(logic [N-1:0] pend, int p);
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (pend[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (pend[(p + k) % N]) return (p + k) % N;
`endif
    return -1;
  endfunction

  task automatic push_item(int i);
    item_t e;
    e.id = i;
    e.sel = req_sel[2*i +: 2];
    e.data = req_data[8*i +: 8];
    e.er = (e.sel == 2'b11);
    e.rsp = e.er ? 8'hFF : slave_resp(e.data, e.sel);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals();
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_m_slave_select", m_slave_select, 2'b11);
    chk("rst_m_data_to_send", m_data_to_send, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_grant_id", grant_id, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || req != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("wait_idle_timeout", n, 0);
  endtask

  task automatic round(logic [N-1:0] mask, bit use_x, int x);
    logic [N-1:0] pend;
    int p, w, n;
    pend = mask;
    p = mptr;
    w = pick(pend, p);
    push_item(w);
    pend[w] = 1'b0;
    p = w;
    if (use_x) pend[x] = 1'b1;
    while (pend != 0) begin
      w = pick(pend, p);
      push_item(w);
      pend[w] = 1'b0;
      p = w;
    end
    mptr = p;
    req = mask;
    if (use_x) begin
      n = 0;
      while (!busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) chk("busy_timeout", n, 0);
      repeat (2) @(negedge clk);
      req[x] = 1'b1;
    end
  endtask

  task automatic measure(int i, int want, string nm);
    int n = 0;
    while (ack[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, want);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    req = req & ~drop;
    drop = ack;
  end

  initial begin
    logic [7:0] r;
    forever begin
      @(posedge clk);
      #1;
      if (reset && m_start) begin
        r = slave_resp(m_data_to_send, m_slave_select);
        m_data_received = ~r;
        repeat (XF) @(posedge clk);
        #1 m_data_received = r;
        @(posedge clk);
        #1 m_data_received = ~r;
      end
    end
  end

  initial begin
    int cyc, last_ack, last_start;
    bit started, prev_start, gap_chk;
    item_t e;
    cyc = 0;
    last_ack = -100;
    last_start = -100;
    started = 0;
    prev_start = 0;
    gap_chk = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        started = 0;
        prev_start = 0;
        gap_chk = 0;
        last_ack = -100;
        last_start = -100;
        continue;
      end
      if (gap_chk) begin
        chk("gap_select", m_slave_select, 2'b11);
        chk("gap_busy", busy, 1);
      end
      gap_chk = 0;
      if (m_start) begin
        chk("start_pulse_width", prev_start, 0);
        chk("start_spacing", 32'(cyc - last_ack >= 2 + GP), 1);
        chk("start_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("start_select", m_slave_select, exp_q[0].sel);
          chk("start_data", m_data_to_send, exp_q[0].data);
        end
        started = 1;
        last_start = cyc;
      end
      prev_start = m_start;
      if (ack != 0) begin
        if (exp_q.size() == 0) chk("ack_unexpected", ack, 0);
        else begin
          e = exp_q.pop_front();
          chk("ack_id", ack, 1 << e.id);
          chk("grant_id", grant_id, e.id);
          chk("rsp_data", rsp_data, e.rsp);
          chk("err", err, e.er);
          if (e.er) begin
            chk("err_no_start", started, 0);
            chk("err_spacing", 32'(cyc - last_ack >= 2 + GP), 1);
          end else begin
            chk("ack_latency", cyc - last_start, XF + 1);
            chk("capture_select", m_slave_select, e.sel);
            chk("capture_data", m_data_to_send, e.data);
          end
        end
        last_ack = cyc;
        started = 0;
        gap_chk = 1;
      end else if (err) chk("err_without_ack", err, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, x;
    logic [N-1:0] mask;
    bit use_x;
    #1 reset = 1'b0;
    #1 check_reset_vals();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req_sel[1:0] = 2'b01;
    req_data[7:0] = 8'hA5;
    round(3'b001, 0, 0);
    measure(0, XF + 2, "single_latency");
    wait_idle();
    req_sel = {2'b10, 2'b01, 2'b00};
    req_data = {8'h33, 8'h22, 8'h11};
    round(3'b111, 0, 0);
    wait_idle();
    req_sel[3:2] = 2'b11;
    req_data[15:8] = 8'h5C;
    round(3'b010, 0, 0);
    measure(1, 1, "err_latency");
    wait_idle();
    req_sel[1:0] = 2'b10;
    req_data[7:0] = 8'hC3;
    round(3'b001, 0, 0);
    n = 0;
    while (!m_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("start_timeout", n, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_reset_vals();
    repeat (12) @(negedge clk);
    reset = 1'b1;
    wait_idle();
    req_sel[1:0] = 2'b01;
    req_data[7:0] = 8'h5A;
    req_sel[5:4] = 2'b00;
    req_data[23:16] = 8'h77;
    round(3'b001, 1, 2);
    wait_idle();
    for (int t = 0; t < 30; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        req_sel[2*i +: 2] = 2'($urandom_range(0, 3));
        req_data[8*i +: 8] = 8'($urandom);
      end
      use_x = (mask != '1) && ($urandom_range(0, 1) == 1);
      x = 0;
      if (use_x) begin
        x = $urandom_range(0, N - 1);
        while (mask[x]) x = $urandom_range(0, N - 1);
      end
      round(mask, use_x, x);
      wait_idle();
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
